// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant identifiers
// and the width of the latency and streak counters.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Winner selection between fetch and data requests. Data normally wins a
// tie, but a streak counter of data grants made while a fetch waits hands
// the port to fetch once the streak reaches STARVE_MAX.
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   idle,
    input  logic   gnt_evt,
    input  grant_t gnt_type,
    output grant_t winner
);

    localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] streak;

    // Streak counter: counts data grants that overtook a pending fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if ((idle && !if_req) || (gnt_evt && gnt_type == GNT_IF)) begin
            streak <= '0;
        end else if (gnt_evt && if_req && streak != STREAK_LIM) begin
            streak <= streak + 1'b1;
        end
    end

    // Winner: fetch when it is alone or when data has starved it long enough.
    always_comb begin
        winner = GNT_D;
        if (if_req && (!d_req || streak == STREAK_LIM)) begin
            winner = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port sequencer: arbitrates fetch and data requests, issues
// one fixed-latency access at a time and returns the read data.
// Optional alignment checking is enabled by MEM_ARB_ALIGN_CHECK_EN; when it
// is undefined the error outputs stay 0 and addresses pass through as-is.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);

    // Handshake: a requester holds req and its fields stable until the
    // one-cycle ack; the matching rvalid pulse arrives later and always
    // follows exactly one ack. Requests seen outside IDLE simply wait.

    state_t           state;
    state_t           state_nx;
    grant_t           winner;
    grant_t           gnt;
    logic             idle;
    logic             gnt_evt;
    logic             mis_now;
    logic             lat_we;
    logic             lat_mis;
    logic [63:0]      lat_addr;
    logic [63:0]      lat_wdata;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      cap;

    assign idle    = (state == IDLE);
    assign gnt_evt = idle && (if_req || d_req);

    arb_priority #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .idle     (idle),
        .gnt_evt  (gnt_evt),
        .gnt_type (winner),
        .winner   (winner)
    );

    // Misalignment of the request about to be granted.
    always_comb begin
        mis_now = 1'b0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        if (winner == GNT_IF) begin
            mis_now = (if_addr[1:0] != 2'b00);
        end else begin
            mis_now = (d_addr[2:0] != 3'b000);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: stores and rejected accesses skip the latency wait.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (gnt_evt) state_nx = ISSUE;
            ISSUE: state_nx = (lat_mis || lat_we) ? RESP : WAIT;
            WAIT:  if (cnt == '0) state_nx = RESP;
            RESP:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch the winner, run the latency counter, capture read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= GNT_IF;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            cap       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_evt) begin
                        gnt       <= winner;
                        lat_we    <= (winner == GNT_D) && d_we;
                        lat_mis   <= mis_now;
                        lat_addr  <= (winner == GNT_IF) ? if_addr : d_addr;
                        lat_wdata <= d_wdata;
                    end
                end
                ISSUE: begin
                    cnt <= CNT_W'(MEM_LAT - 1);
                    if (lat_mis) begin
                        cap <= '0;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        cap <= mem_rdata;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: pulses in ISSUE and RESP only; everything else is 0.
    always_comb begin
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_err    = 1'b0;
        d_err     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            ISSUE: begin
                if (gnt == GNT_IF) if_ack = 1'b1;
                else               d_ack  = 1'b1;
                if (!lat_mis) begin
                    mem_addr = lat_addr;
                    if (lat_we) begin
                        mem_wr    = 1'b1;
                        mem_wdata = lat_wdata;
                    end else begin
                        mem_rd = 1'b1;
                    end
                end
            end
            RESP: begin
                if (gnt == GNT_IF) begin
                    if_rvalid = 1'b1;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                    if_err    = lat_mis;
`endif
                end else begin
                    d_rvalid = 1'b1;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                    d_err    = lat_mis;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign if_rdata = cap[63:32];
    assign d_rdata  = cap;

endmodule
